// File: rtl/joypad_if.sv
// joypad_if: $4016/$4017 controller port pair with pin synchronizer, debounce,
// strobe latch and two serial read shift registers.
module joypad_if #(
    parameter int DEB_CYCLES = 21477,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       sel,
    input  logic       a0,
    input  logic       rw,
    input  logic [7:0] din,
    input  logic [7:0] open_bus,
    output logic [7:0] dout,
    output logic       dout_en,
    input  logic [7:0] pad1_pins,
    input  logic [7:0] pad2_pins,
    output logic       strobe
);
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [15:0] PIN_REL = ACTIVE_LOW ? 16'hffff : 16'h0000;

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0][7:0] sa_q, sa_d, sb_q, sb_d, prev_q, prev_d, deb_q, deb_d, sr_q, sr_d;
    logic [1:0][7:0] pins, s, same;
    logic            strobe_q, strobe_d;
    logic            tick, rd, serial_bit;
    logic            unused;

    assign pins   = {pad2_pins, pad1_pins};
    assign unused = ^{din[7:1], open_bus[0]};

    always_comb begin
        tick       = cnt_q == CW'(DEB_CYCLES - 1);
        cnt_d      = tick ? '0 : cnt_q + CW'(1);
        sa_d       = pins;
        sb_d       = sa_q;
        s          = ACTIVE_LOW ? ~sb_q : sb_q;
        same       = ~(s ^ prev_q);
        prev_d     = tick ? s : prev_q;
        // a button only follows the pin once two consecutive ticks agree
        deb_d      = tick ? ((s & same) | (deb_q & ~same)) : deb_q;
        strobe_d   = (ce & sel & ~rw & ~a0) ? din[0] : strobe_q;
        rd         = ce & sel & rw;
        sr_d[0]    = strobe_q ? deb_q[0] : (rd & ~a0) ? {1'b1, sr_q[0][7:1]} : sr_q[0];
        sr_d[1]    = strobe_q ? deb_q[1] : (rd & a0) ? {1'b1, sr_q[1][7:1]} : sr_q[1];
        serial_bit = strobe_q ? deb_q[a0][0] : sr_q[a0][0];
        dout_en    = sel & rw;
        dout       = {open_bus[7:1], dout_en & serial_bit};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            sa_q     <= PIN_REL;
            sb_q     <= PIN_REL;
            prev_q   <= '0;
            deb_q    <= '0;
            sr_q     <= '0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            prev_q   <= prev_d;
            deb_q    <= deb_d;
            sr_q     <= sr_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe = strobe_q;
endmodule

// File: tb/tb_joypad_if.sv
// tb_joypad_if: randomized bench for joypad_if against a button-list read model.
module tb_joypad_if;
    localparam int DEB = 16;
    localparam int SETTLE = 3 * DEB + 6;

    logic       clk = 1'b0, reset = 1'b1, ce = 1'b0, sel = 1'b0, a0 = 1'b0, rw = 1'b1;
    logic [7:0] din = 8'h00, open_bus = 8'h00, dout;
    logic       dout_en, strobe;
    logic [7:0] pad1_pins = 8'hff, pad2_pins = 8'hff;

    int total = 0, bad = 0;

    // model: pressed buttons per pad, latched snapshot, reads consumed, strobe
    logic [7:0] pr [2];
    logic [7:0] lat [2];
    int         n [2];
    logic       strb;

    joypad_if #(.DEB_CYCLES(DEB), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset(reset), .ce(ce), .sel(sel), .a0(a0), .rw(rw),
        .din(din), .open_bus(open_bus), .dout(dout), .dout_en(dout_en),
        .pad1_pins(pad1_pins), .pad2_pins(pad2_pins), .strobe(strobe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_pins(input logic [7:0] p1, input logic [7:0] p2);
        @(negedge clk);
        pad1_pins = p1;
        pad2_pins = p2;
        repeat (SETTLE) @(negedge clk);
        pr[0] = ~p1;
        pr[1] = ~p2;
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        @(negedge clk);
        ce = 1'b1; sel = 1'b1; rw = 1'b0; a0 = a; din = d;
        @(posedge clk);
        #1 ce = 1'b0; sel = 1'b0; rw = 1'b1;
        if (!a) begin
            if (strb && !d[0]) begin
                lat[0] = pr[0]; lat[1] = pr[1]; n[0] = 0; n[1] = 0;
            end
            strb = d[0];
        end
        chk("strobe_after_write", {7'd0, strobe}, {7'd0, strb});
    endtask

    task automatic rd(input logic a, input logic with_ce, input string tag);
        logic exp_bit;
        int   ai;
        ai = a ? 1 : 0;
        exp_bit = strb ? pr[ai][0] : (n[ai] < 8 ? lat[ai][n[ai]] : 1'b1);
        @(negedge clk);
        ce = with_ce; sel = 1'b1; rw = 1'b1; a0 = a; open_bus = 8'($urandom);
        #1;
        chk(tag, {7'd0, dout[0]}, {7'd0, exp_bit});
        chk("open_bus_bits", {1'b0, dout[7:1]}, {1'b0, open_bus[7:1]});
        chk("dout_en_read", {7'd0, dout_en}, 8'd1);
        @(posedge clk);
        #1 ce = 1'b0; sel = 1'b0;
        if (with_ce && !strb) n[ai]++;
    endtask

    initial begin
        logic ever;
        pr[0] = 0; pr[1] = 0; lat[0] = 0; lat[1] = 0; n[0] = 0; n[1] = 0; strb = 1'b0;
        repeat (3) @(negedge clk);
        open_bus = 8'hA5;
        #1;
        chk("reset_strobe", {7'd0, strobe}, 8'd0);
        chk("reset_dout", dout, 8'hA4);
        chk("reset_dout_en", {7'd0, dout_en}, 8'd0);
        reset = 1'b0;

        // empty register shifts in ones from the top; ninth read sees the first
        for (int i = 0; i < 9; i++) rd(1'b0, 1'b1, "rst_pad1_read");
        rd(1'b1, 1'b1, "rst_pad2_read");

        // strobe held high: every read returns live A, no shifting
        set_pins(8'b1111_0110, 8'b0111_1110);
        wr(1'b0, 8'h01);
        for (int i = 0; i < 4; i++) rd(1'b0, 1'b1, "strobe_live_a");
        set_pins(8'b1111_0111, 8'b0111_1110);
        rd(1'b0, 1'b1, "strobe_a_released");
        rd(1'b1, 1'b1, "strobe_pad2_a");
        wr(1'b0, 8'h00);
        for (int i = 0; i < 10; i++) rd(1'b0, 1'b1, "seq_pad1");
        wr(1'b0, 8'h01);
        wr(1'b0, 8'h00);
        for (int i = 0; i < 3; i++) rd(1'b1, 1'b1, "cross_pad2");
        rd(1'b0, 1'b1, "cross_pad1_unshifted");

        // glitch shorter than a debounce period must never register
        set_pins(8'hff, 8'hff);
        wr(1'b0, 8'h01);
        ever = 1'b0;
        @(negedge clk);
        sel = 1'b1; rw = 1'b1; a0 = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            pad1_pins[0] = (i < 5) ? 1'b0 : 1'b1;
            #1 ever |= dout[0];
        end
        chk("glitch_rejected", {7'd0, ever}, 8'd0);
        @(negedge clk);
        pad1_pins[0] = 1'b0;
        repeat (40) @(negedge clk);
        #1 chk("held_accepted", {7'd0, dout[0]}, 8'd1);
        sel = 1'b0;
        pr[0] = ~pad1_pins;
        wr(1'b0, 8'h00);

        // reset in the middle of a read sequence
        for (int i = 0; i < 3; i++) rd(1'b0, 1'b1, "pre_reset_read");
        @(negedge clk);
        reset = 1'b1;
        #1 chk("midseq_reset_strobe", {7'd0, strobe}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        strb = 1'b0; lat[0] = 0; lat[1] = 0; n[0] = 0; n[1] = 0;
        rd(1'b0, 1'b1, "post_reset_read");
        wr(1'b1, 8'h01);
        set_pins(pad1_pins, pad2_pins);

        for (int it = 0; it < 25; it++) begin
            set_pins(8'($urandom), 8'($urandom));
            wr(1'b0, 8'h01);
            if (it % 2 == 1)
                for (int k = 0; k < 3; k++) rd(1'($urandom), 1'b1, "rand_strobe_read");
            wr(1'b0, 8'h00);
            for (int k = 0; k < int'($urandom_range(6, 20)); k++) begin
                case ($urandom_range(0, 9))
                    0: wr(1'b1, 8'($urandom));
                    1: rd(1'($urandom), 1'b0, "rand_read_noce");
                    default: rd(1'($urandom), 1'b1, "rand_read");
                endcase
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
